multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//   Multi-cycle control sequencer for the MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB.
//   Emits per-state control strobes (IR/PC/regfile/ALU/memory) and waits on the memory handshake.
//   Handles stall opcodes, illegal-instruction detection and memory timeouts.
//   Sits between the instruction register (opcode/funct) and the datapath muxes.
// PARAMETERS
//   MEM_TIMEOUT   15  cycles without mem_ready before a memory access is abandoned
//   STALL_CYCLES  4   cycles the STALL opcode (6'b000110) holds the sequencer
// PORTS
//   clk         in   1  clock; all state changes on posedge
//   rst         in   1  synchronous, active-high reset
//   opcode      in   6  IR[31:26]; valid from DECODE onward
//   funct       in   6  IR[5:0]; valid from DECODE onward
//   zero        in   1  ALU zero flag, sampled in EXEC
//   mem_ready   in   1  memory completes the access this cycle
//   stall_req   in   1  external hold; honoured only in FETCH
//   load_ir     out  1  IR load strobe
//   inc_pc      out  1  PC <= PC+4
//   load_pc     out  1  PC <= pc_sel source
//   pc_sel      out  2  00 pc+4, 01 branch target, 10 jump target, 11 register (jr)
//   reg_write   out  1  register file write enable
//   reg_dst     out  2  00 rt, 01 rd, 10 r31
//   mem_to_reg  out  1  writeback from memory data
//   alu_src     out  1  0 register, 1 sign-extended immediate
//   alu_ctrl    out  4  0000 pass, 0001 add, 0010 sub, 0011 nor, 0100 and, 0101 sll, 0110 srl
//   mem_read    out  1  memory read request
//   mem_write   out  1  memory write request
//   instr_done  out  1  1-cycle pulse in the final cycle of each instruction
//   illegal     out  1  1-cycle pulse: undefined opcode/funct decoded
//   mem_err     out  1  1-cycle pulse: memory timeout
// BEHAVIOUR
//   Reset: state FETCH; all outputs 0; wait and stall counters 0. Reset mid-access drops mem_write at the same edge.
//   FETCH: mem_read=1.
//     - mem_ready: load_ir=1 and inc_pc=1 in that cycle, then go to DECODE.
//     - stall_req=1: mem_read=0 and counters frozen; the state is held.
//     - No mem_ready within MEM_TIMEOUT counted cycles: mem_err pulse, counter cleared, fetch retried.
//   DECODE (1 cycle):
//     - nop 111111: instr_done, go to FETCH.
//     - Undefined code: illegal pulse plus instr_done, go to FETCH.
//     - stall 000110: go to STALL. STALL lasts exactly STALL_CYCLES cycles, then instr_done and FETCH.
//     - j 000010: load_pc, pc_sel=10, go to FETCH.
//     - jal 000011: additionally reg_write=1, reg_dst=10.
//     - jr (R-type, funct 001000): load_pc, pc_sel=11, go to FETCH.
//     - Everything else: go to EXEC.
//   EXEC (1 cycle):
//     - alu_ctrl and alu_src are driven from decode. R-type: alu_src=0. addi 001000 / andi 001100 / lw 110000 / sw 101011: alu_src=1.
//     - beq 000100: load_pc, pc_sel=01 iff zero=1. bne 000101: iff zero=0. Both use alu_ctrl=sub, then instr_done and FETCH.
//     - lw/sw go to MEM; ALU ops go to WB.
//   MEM: mem_read (lw) or mem_write (sw) held until mem_ready.
//     - sw: instr_done, go to FETCH.
//     - lw: go to WB.
//     - Timeout: mem_err pulse, no writeback, instr_done, go to FETCH.
//   WB (1 cycle): reg_write=1; reg_dst=01 for R-type, 00 for I-type/lw; mem_to_reg=1 for lw only. Then instr_done and FETCH.
//   alu_ctrl stays stable from EXEC through MEM/WB; it is 0000 in FETCH/DECODE.
//   Latency with mem_ready immediate (cycles):
//     j/jal/jr/nop = 2; beq/bne = 3; R-type/addi/andi/sw = 4; lw = 5; stall = 2+STALL_CYCLES.
//   Counter width: $clog2(max(MEM_TIMEOUT, STALL_CYCLES)+1). No wrap: the counter clears on a state change.
//   mem_ready outside FETCH/MEM is ignored. Strobes are mutually consistent: load_pc and inc_pc are never both 1.
// STRUCTURE
//   Package cpu_ctrl_pkg: opcode/funct constants, ALU codes, pc_sel/reg_dst codes, state encoding (3 bits).
//   Sub-module ctrl_decode: combinational opcode/funct -> instruction class, alu_ctrl, alu_src, legal.
//   Top: state register, wait/stall counter, per-state output logic.
// TESTING
//   add (000000/100000), mem_ready tied 1 -> states F,D,E,W; alu_ctrl=0001 in E; reg_write=1, reg_dst=01 in W; instr_done on cycle 4.
//   lw, mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles; W has mem_to_reg=1, reg_dst=00.
//   beq with zero=1 -> load_pc=1, pc_sel=01 in E; with zero=0 -> load_pc=0. bne gives the inverse.
//   sw, mem_ready never asserted -> mem_err pulse after 15 wait cycles; mem_write drops; back in FETCH; reg_write never 1.
//   opcode 000110 -> exactly 4 STALL cycles with all strobes 0, then FETCH. Opcode 111110 -> illegal pulse in D.
//   rst=1 during MEM of sw -> next cycle: FETCH, mem_write=0, all outputs 0. stall_req in FETCH -> mem_read=0, no timeout.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, functs, ALU/PC/reg_dst
// codes, FSM state encoding and the instruction class used between decode and sequencer.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_STALL = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b110000;
    localparam logic [5:0] OP_NOP   = 6'b111111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_STALL  = 3'd5;

    typedef enum logic [3:0] {
        IC_ILLEGAL, IC_NOP, IC_STALL, IC_J, IC_JAL, IC_JR,
        IC_BEQ, IC_BNE, IC_LW, IC_SW, IC_RALU, IC_IALU
    } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode/funct to instruction class, ALU
// operation, ALU operand select and a legality flag.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [3:0] alu_ctrl,
    output logic       alu_src,
    output logic       legal
);

    always_comb begin
        iclass   = IC_ILLEGAL;
        alu_ctrl = ALU_PASS;
        alu_src  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin iclass = IC_RALU; alu_ctrl = ALU_ADD; end
                    FN_SUB: begin iclass = IC_RALU; alu_ctrl = ALU_SUB; end
                    FN_AND: begin iclass = IC_RALU; alu_ctrl = ALU_AND; end
                    FN_NOR: begin iclass = IC_RALU; alu_ctrl = ALU_NOR; end
                    FN_SLL: begin iclass = IC_RALU; alu_ctrl = ALU_SLL; end
                    FN_SRL: begin iclass = IC_RALU; alu_ctrl = ALU_SRL; end
                    FN_JR:  iclass = IC_JR;
                    default: iclass = IC_ILLEGAL;
                endcase
            end
            OP_ADDI:  begin iclass = IC_IALU; alu_ctrl = ALU_ADD; alu_src = 1'b1; end
            OP_ANDI:  begin iclass = IC_IALU; alu_ctrl = ALU_AND; alu_src = 1'b1; end
            OP_LW:    begin iclass = IC_LW;   alu_ctrl = ALU_ADD; alu_src = 1'b1; end
            OP_SW:    begin iclass = IC_SW;   alu_ctrl = ALU_ADD; alu_src = 1'b1; end
            OP_BEQ:   begin iclass = IC_BEQ;  alu_ctrl = ALU_SUB; end
            OP_BNE:   begin iclass = IC_BNE;  alu_ctrl = ALU_SUB; end
            OP_J:     iclass = IC_J;
            OP_JAL:   iclass = IC_JAL;
            OP_STALL: iclass = IC_STALL;
            OP_NOP:   iclass = IC_NOP;
            default:  iclass = IC_ILLEGAL;
        endcase
    end

    assign legal = (iclass != IC_ILLEGAL);

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer with a shared wait/stall counter,
// memory handshake timeout and per-state control strobes.
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned STALL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       stall_req,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic [1:0] pc_sel,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic [3:0] alu_ctrl,
    output logic       mem_read,
    output logic       mem_write,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    localparam int unsigned CNT_MAX = (MEM_TIMEOUT > STALL_CYCLES) ? MEM_TIMEOUT : STALL_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 1);

    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             idle;
    iclass_t          iclass;
    logic [3:0]       dec_alu_ctrl;
    logic             dec_alu_src;
    logic             legal;

    ctrl_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .iclass   (iclass),
        .alu_ctrl (dec_alu_ctrl),
        .alu_src  (dec_alu_src),
        .legal    (legal)
    );

    // idle holds every output low for the first cycle after reset, so a reset
    // during a memory access drops the request at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            cnt   <= '0;
            idle  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idle  <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_ir    = 1'b0;
        inc_pc     = 1'b0;
        load_pc    = 1'b0;
        pc_sel     = PC_SEQ;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = ALU_PASS;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        if (!idle) begin
            case (state)
                S_FETCH: begin
                    if (!stall_req) begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            load_ir    = 1'b1;
                            inc_pc     = 1'b1;
                            state_next = S_DECODE;
                            cnt_next   = '0;
                        end else if (cnt == TO_LAST) begin
                            mem_err  = 1'b1;
                            cnt_next = '0;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        case (iclass)
                            IC_NOP: begin
                                instr_done = 1'b1;
                                state_next = S_FETCH;
                            end
                            IC_STALL: begin
                                state_next = S_STALL;
                                cnt_next   = '0;
                            end
                            IC_J, IC_JAL, IC_JR: begin
                                load_pc    = 1'b1;
                                pc_sel     = (iclass == IC_JR) ? PC_REG : PC_JUMP;
                                reg_write  = (iclass == IC_JAL);
                                reg_dst    = (iclass == IC_JAL) ? RD_R31 : RD_RT;
                                instr_done = 1'b1;
                                state_next = S_FETCH;
                            end
                            default: state_next = S_EXEC;
                        endcase
                    end
                end
                S_EXEC: begin
                    alu_ctrl = dec_alu_ctrl;
                    alu_src  = dec_alu_src;
                    case (iclass)
                        IC_BEQ, IC_BNE: begin
                            load_pc    = (iclass == IC_BEQ) ? zero : !zero;
                            pc_sel     = load_pc ? PC_BRANCH : PC_SEQ;
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                        IC_LW, IC_SW: begin
                            state_next = S_MEM;
                            cnt_next   = '0;
                        end
                        default: state_next = S_WB;
                    endcase
                end
                S_MEM: begin
                    alu_ctrl  = dec_alu_ctrl;
                    alu_src   = dec_alu_src;
                    mem_read  = (iclass == IC_LW);
                    mem_write = (iclass == IC_SW);
                    if (mem_ready) begin
                        cnt_next = '0;
                        if (iclass == IC_LW) begin
                            state_next = S_WB;
                        end else begin
                            instr_done = 1'b1;
                            state_next = S_FETCH;
                        end
                    end else if (cnt == TO_LAST) begin
                        mem_err    = 1'b1;
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    alu_ctrl   = dec_alu_ctrl;
                    alu_src    = dec_alu_src;
                    reg_write  = 1'b1;
                    reg_dst    = (iclass == IC_RALU) ? RD_RD : RD_RT;
                    mem_to_reg = (iclass == IC_LW);
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
                S_STALL: begin
                    if (cnt == STALL_LAST) begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = S_FETCH;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-scenario tasks compare the full
// strobe vector against hand-written expectations each cycle.
module tb_multicycle_sequencer;

    typedef struct packed {
        logic       li;
        logic       ip;
        logic       lp;
        logic [1:0] ps;
        logic       rw;
        logic [1:0] rd;
        logic       m2r;
        logic       as;
        logic [3:0] ac;
        logic       mr;
        logic       mw;
        logic       id;
        logic       il;
        logic       me;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready, stall_req;
    logic [5:0] opcode, funct;
    logic       load_ir, inc_pc, load_pc, reg_write, mem_to_reg, alu_src;
    logic       mem_read, mem_write, instr_done, illegal, mem_err;
    logic [1:0] pc_sel, reg_dst;
    logic [3:0] alu_ctrl;

    outs_t o, e;
    int    tests = 0;
    int    fails = 0;

    assign o = {load_ir, inc_pc, load_pc, pc_sel, reg_write, reg_dst, mem_to_reg,
                alu_src, alu_ctrl, mem_read, mem_write, instr_done, illegal, mem_err};

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(15), .STALL_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .stall_req(stall_req),
        .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .pc_sel(pc_sel),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .mem_read(mem_read),
        .mem_write(mem_write), .instr_done(instr_done), .illegal(illegal),
        .mem_err(mem_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From a FETCH sample point: fetch the instruction and advance into EXEC.
    task automatic go_exec(input logic [5:0] op, input logic [5:0] fn);
        opcode = op; funct = fn; mem_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; stall_req = 1'b0; zero = 1'b0;
        opcode = 6'b000000; funct = 6'b100000;
        tick(); tick();
        e = '0;
        tests++; if (o !== e) begin fails++; $display("FAIL reset_outputs: got %b want %b", o, e); end
        rst = 1'b0; mem_ready = 1'b0;
        tick();
        e = '0; e.mr = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL post_reset_fetch: got %b want %b", o, e); end
    endtask

    task automatic test_add();
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1; #1;
        e = '0; e.mr = 1'b1; e.li = 1'b1; e.ip = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL add_fetch: got %b want %b", o, e); end
        tick();
        e = '0;
        tests++; if (o !== e) begin fails++; $display("FAIL add_decode: got %b want %b", o, e); end
        tick();
        e = '0; e.ac = 4'b0001;
        tests++; if (o !== e) begin fails++; $display("FAIL add_exec: got %b want %b", o, e); end
        tick();
        e = '0; e.ac = 4'b0001; e.rw = 1'b1; e.rd = 2'b01; e.id = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL add_wb: got %b want %b", o, e); end
        tick();
    endtask

    task automatic test_alu_ops();
        logic [5:0] op [6] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b001100};
        logic [5:0] fn [6] = '{6'b100010, 6'b100111, 6'b000000, 6'b000010, 6'b000000, 6'b000000};
        logic [3:0] ac [6] = '{4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0001, 4'b0100};
        logic       im [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            go_exec(op[i], fn[i]);
            e = '0; e.ac = ac[i]; e.as = im[i];
            tests++; if (o !== e) begin fails++; $display("FAIL alu_exec[%0d]: got %b want %b", i, o, e); end
            tick();
            e.rw = 1'b1; e.rd = im[i] ? 2'b00 : 2'b01; e.id = 1'b1;
            tests++; if (o !== e) begin fails++; $display("FAIL alu_wb[%0d]: got %b want %b", i, o, e); end
            tick();
        end
    endtask

    task automatic test_lw();
        go_exec(6'b110000, 6'b000000);
        e = '0; e.ac = 4'b0001; e.as = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL lw_exec: got %b want %b", o, e); end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = '0; e.ac = 4'b0001; e.as = 1'b1; e.mr = 1'b1;
            tests++; if (o !== e) begin fails++; $display("FAIL lw_mem_wait[%0d]: got %b want %b", i, o, e); end
        end
        tick();
        mem_ready = 1'b1; #1;
        e = '0; e.ac = 4'b0001; e.as = 1'b1; e.mr = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL lw_mem_ready: got %b want %b", o, e); end
        tick();
        e = '0; e.ac = 4'b0001; e.as = 1'b1; e.rw = 1'b1; e.rd = 2'b00; e.m2r = 1'b1; e.id = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL lw_wb: got %b want %b", o, e); end
        tick();
    endtask

    task automatic test_branch();
        logic [5:0] op [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        logic       zf [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            zero = zf[i];
            go_exec(op[i], 6'b000000);
            e = '0; e.ac = 4'b0010; e.lp = tk[i]; e.ps = tk[i] ? 2'b01 : 2'b00; e.id = 1'b1;
            tests++; if (o !== e) begin fails++; $display("FAIL branch_exec[%0d]: got %b want %b", i, o, e); end
            tick();
        end
        zero = 1'b0;
    endtask

    task automatic test_sw_timeout();
        go_exec(6'b101011, 6'b000000);
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            e = '0; e.ac = 4'b0001; e.as = 1'b1; e.mw = 1'b1;
            e.id = (i == 14); e.me = (i == 14);
            tests++; if (o !== e) begin fails++; $display("FAIL sw_timeout[%0d]: got %b want %b", i, o, e); end
        end
        tick();
        e = '0; e.mr = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL sw_timeout_refetch: got %b want %b", o, e); end
    endtask

    task automatic test_stall_op();
        opcode = 6'b000110; funct = 6'b000000; mem_ready = 1'b1;
        tick();
        e = '0;
        tests++; if (o !== e) begin fails++; $display("FAIL stall_decode: got %b want %b", o, e); end
        for (int i = 0; i < 4; i++) begin
            tick();
            e = '0; e.id = (i == 3);
            tests++; if (o !== e) begin fails++; $display("FAIL stall_cycle[%0d]: got %b want %b", i, o, e); end
        end
        tick();
        e = '0; e.mr = 1'b1; e.li = 1'b1; e.ip = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL stall_refetch: got %b want %b", o, e); end
    endtask

    task automatic test_illegal();
        opcode = 6'b111110; funct = 6'b000000; mem_ready = 1'b1;
        tick();
        e = '0; e.il = 1'b1; e.id = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL illegal_op: got %b want %b", o, e); end
        tick();
        opcode = 6'b000000; funct = 6'b111111;
        tick();
        tests++; if (o !== e) begin fails++; $display("FAIL illegal_funct: got %b want %b", o, e); end
        tick();
    endtask

    task automatic test_jumps();
        logic [5:0] op [4] = '{6'b000010, 6'b000011, 6'b000000, 6'b111111};
        logic [5:0] fn [4] = '{6'b000000, 6'b000000, 6'b001000, 6'b000000};
        logic [1:0] ps [4] = '{2'b10, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) begin
            opcode = op[i]; funct = fn[i]; mem_ready = 1'b1;
            tick();
            e = '0; e.id = 1'b1; e.lp = (i < 3); e.ps = ps[i];
            e.rw = (i == 1); e.rd = (i == 1) ? 2'b10 : 2'b00;
            tests++; if (o !== e) begin fails++; $display("FAIL jump_decode[%0d]: got %b want %b", i, o, e); end
            tick();
        end
    endtask

    task automatic test_reset_mid_sw();
        go_exec(6'b101011, 6'b000000);
        mem_ready = 1'b0;
        tick();
        e = '0; e.ac = 4'b0001; e.as = 1'b1; e.mw = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL rst_sw_mem: got %b want %b", o, e); end
        rst = 1'b1;
        tick();
        e = '0;
        tests++; if (o !== e) begin fails++; $display("FAIL rst_sw_dropped: got %b want %b", o, e); end
        rst = 1'b0;
        tick();
        e = '0; e.mr = 1'b1;
        tests++; if (o !== e) begin fails++; $display("FAIL rst_sw_fetch: got %b want %b", o, e); end
    endtask

    task automatic test_fetch_stall();
        stall_req = 1'b1; mem_ready = 1'b0; #1;
        for (int i = 0; i < 20; i++) begin
            e = '0;
            tests++; if (o !== e) begin fails++; $display("FAIL fetch_stall[%0d]: got %b want %b", i, o, e); end
            tick();
        end
        stall_req = 1'b0; #1;
        for (int i = 0; i < 15; i++) begin
            e = '0; e.mr = 1'b1; e.me = (i == 14);
            tests++; if (o !== e) begin fails++; $display("FAIL fetch_timeout[%0d]: got %b want %b", i, o, e); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_lw();
        test_branch();
        test_sw_timeout();
        test_stall_op();
        test_illegal();
        test_jumps();
        test_reset_mid_sw();
        test_fetch_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
